mem_arbiter: RTL
================

# mem_arbiter

Shares the single data-memory port (Memoria64-style, synchronous read, write strobe) between the instruction-fetch requester and the load/store requester of the processor. This lets a unified memory replace the separate instruction and data memories. Each accepted request is sequenced through a fixed-latency access and returned with a one-cycle response pulse to the requester that issued it. Data accesses have fixed priority over fetch, with an optional anti-starvation guard.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MEM_LAT, 1, cycles from mem_addr valid to mem_rdata valid (>=1)
- STARVE_MAX, 4, consecutive data grants tolerated while if_req is pending (>=1; used only with guard)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch data; holds until next fetch response
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data accepted (1-cycle pulse)
- d_rvalid  out  1  read data valid or write acknowledge (1-cycle pulse)
- d_rdata  out  DATA_W  read data; unchanged on write ack
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- FSM states: ARB_IDLE, ARB_ACCESS, ARB_RESP.
- Arbitration happens in IDLE and RESP. If any request is present, the winner's gnt is driven combinationally in that cycle. The arbiter latches the winner's id, address, we and wdata, then moves to ACCESS. With no request, RESP goes to IDLE.
- Winner selection: d_req beats if_req, except when the starvation guard forces a fetch grant (see Configuration).
- ACCESS:
  - Lasts exactly MEM_LAT cycles.
  - mem_addr and mem_wdata show the latched values.
  - mem_wr is 1 only in the first ACCESS cycle, and only for writes.
  - A down-counter of width $clog2(MEM_LAT+1) counts the latency.
  - At expiry the arbiter samples mem_rdata for reads and goes to RESP.
- RESP:
  - The owner's rvalid is 1 for this one cycle. Read data is registered into if_rdata or d_rdata.
  - A new grant may issue in the same cycle.
- Only one transaction is outstanding at a time. A requester must not change address or data while its req is high and gnt has not yet pulsed.
- Reset values: state IDLE; all gnt, rvalid, mem_wr and busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; counters = 0.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no rvalid is issued.
  - mem_wr drops asynchronously.
  - Requesters re-request after reset.

## Timing
- Grant to rvalid latency is MEM_LAT+1 cycles. Grant is in cycle t, ACCESS covers t+1 to t+MEM_LAT, and RESP is at t+MEM_LAT+1.
- Back-to-back throughput is one transaction per MEM_LAT+1 cycles, because the next grant shares the RESP cycle.
- If d_req and if_req rise in the same cycle, the data request wins and the fetch waits (its gnt is held at 0).
- A req that drops before gnt is allowed. No grant is issued to it.
- mem_addr and mem_wdata hold their last values in IDLE.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A saturating counter (0..STARVE_MAX) increments on every data grant issued while if_req = 1.
  - When the counter equals STARVE_MAX and if_req = 1, the next arbitration grants fetch even if d_req = 1.
  - The counter clears on any fetch grant.
- Macro undefined: strict data priority; the counter logic is absent.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_t enum (ARB_IDLE, ARB_ACCESS, ARB_RESP)
  - arb_id_t enum (ARB_ID_IF, ARB_ID_D)
  - default parameter constants
- Sub-module arb_starve_guard holds the counter plus the forced-fetch decision. It is instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- Reset mid-ACCESS of a read (MEM_LAT=2) -> no d_rvalid; all outputs 0 and busy=0 after rst low.
- Fetch read of 0x40 with mem returning 0x00000013 after MEM_LAT=1 -> if_gnt at t, if_rvalid at t+2 with if_rdata=0x13; busy high at t+1 and t+2.
- Data write of 0xDEADBEEF to 0x100 -> mem_wr=1 for exactly one cycle (t+1) with mem_addr=0x100; d_rvalid at t+2; d_rdata unchanged.
- d_req and if_req both held continuously with the guard disabled -> d_gnt on every arbitration, if_gnt never.
- Same stimulus with MEM_ARB_STARVE_GUARD_EN and STARVE_MAX=4 -> grant pattern D,D,D,D,IF repeating.
- Read response issued back-to-back with a new request -> rvalid and next gnt in the same RESP cycle; rate one transaction per MEM_LAT+1 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified-memory arbiter.
// Imported by mem_arbiter and arb_starve_guard.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        ARB_ID_IF,
        ARB_ID_D
    } arb_id_t;

    localparam int unsigned ADDR_W_DEF     = 64;
    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned MEM_LAT_DEF    = 1;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Data wins unless the starvation guard forces a fetch; only meaningful when some req is present.
    function automatic arb_id_t pick_winner(input logic d_req, input logic force_if);
        return (d_req && !force_if) ? ARB_ID_D : ARB_ID_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_guard.sv
// Anti-starvation guard: counts data grants issued while a fetch waits and forces
// a fetch grant once STARVE_MAX is reached. Built only with MEM_ARB_STARVE_GUARD_EN.
module arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_gnt,
    input  logic if_gnt,
    output logic force_if
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt) begin
            cnt_d = '0;
        end else if (d_gnt && if_req && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign force_if = if_req && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store,
// one fixed-latency transaction at a time. Optional guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

    arb_state_t        state_q, state_d;
    arb_id_t           id_q, id_d;
    logic              we_q, we_d;
    logic              mem_wr_q, mem_wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              force_if;
    logic              arb_en;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_guard #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_guard (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .d_gnt   (d_gnt),
        .if_gnt  (if_gnt),
        .force_if(force_if)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX == 0);
    assign force_if          = 1'b0;
`endif

    // NOTE: every signal written below gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        mem_wr_d   = 1'b0;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        // Grants are combinational, so they are masked while reset is held.
        arb_en     = rst && (state_q != ARB_ACCESS);

        unique case (state_q)
            ARB_IDLE, ARB_RESP: begin
                if (arb_en && (if_req || d_req)) begin
                    id_d = pick_winner(d_req, force_if);
                    if (id_d == ARB_ID_D) begin
                        d_gnt   = 1'b1;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        if_gnt  = 1'b1;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                    mem_wr_d = we_d;
                    cnt_d    = LAT_LOAD;
                    state_d  = ARB_ACCESS;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_RESP;
                    if (!we_q) begin
                        if (id_q == ARB_ID_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            id_q       <= ARB_ID_IF;
            we_q       <= 1'b0;
            mem_wr_q   <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            mem_wr_q   <= mem_wr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_rvalid = (state_q == ARB_RESP) && (id_q == ARB_ID_IF);
    assign d_rvalid  = (state_q == ARB_RESP) && (id_q == ARB_ID_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule
